// File: rtl/jtag_tap_multi.sv
// IEEE 1149.1 TAP with IR_W-bit instruction register and BYPASS, IDCODE,
// SAMPLE and NUM_USER user data registers with per-register update strobes.
module jtag_tap_multi #(
    parameter int          IR_W     = 4,
    parameter int          DR_W     = 8,
    parameter int          NUM_USER = 2,
    parameter logic [31:0] IDCODE   = 32'h1234_5001
) (
    input  logic                     i_tclk,
    input  logic                     i_trst,
    input  logic                     i_tdi,
    input  logic                     i_tms,
    output logic                     o_tdo,
    output logic                     o_tdoEn,
    input  logic [DR_W-1:0]          i_bsr,
    output logic [NUM_USER*DR_W-1:0] o_userData,
    output logic [NUM_USER-1:0]      o_userUpdate,
    output logic [IR_W-1:0]          o_instr,
    output logic [3:0]               o_state
);

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_t;

    typedef enum logic [1:0] {
        SEL_BYPASS, SEL_IDCODE, SEL_SAMPLE, SEL_USER
    } dr_sel_t;

    tap_state_t                state;
    logic [IR_W-1:0]           ir;
    logic [IR_W-1:0]           ir_sr;
    logic                      bypass_sr;
    logic [31:0]               id_sr;
    logic [DR_W-1:0]           data_sr;
    logic [NUM_USER*DR_W-1:0]  user_data;
    logic [NUM_USER-1:0]       user_update;

    dr_sel_t                   dr_sel;
    logic [NUM_USER-1:0]       user_hit;
    logic [DR_W-1:0]           user_rb;

    // TAP state machine; TMS alone steers it.
    always_ff @(posedge i_tclk or posedge i_trst) begin
        if (i_trst) begin
            state <= TLR;
        end else begin
            case (state)
                TLR:     state <= i_tms ? TLR    : RTI;
                RTI:     state <= i_tms ? SEL_DR : RTI;
                SEL_DR:  state <= i_tms ? SEL_IR : CAP_DR;
                CAP_DR:  state <= i_tms ? EX1_DR : SH_DR;
                SH_DR:   state <= i_tms ? EX1_DR : SH_DR;
                EX1_DR:  state <= i_tms ? UPD_DR : PAU_DR;
                PAU_DR:  state <= i_tms ? EX2_DR : PAU_DR;
                EX2_DR:  state <= i_tms ? UPD_DR : SH_DR;
                UPD_DR:  state <= i_tms ? SEL_DR : RTI;
                SEL_IR:  state <= i_tms ? TLR    : CAP_IR;
                CAP_IR:  state <= i_tms ? EX1_IR : SH_IR;
                SH_IR:   state <= i_tms ? EX1_IR : SH_IR;
                EX1_IR:  state <= i_tms ? UPD_IR : PAU_IR;
                PAU_IR:  state <= i_tms ? EX2_IR : PAU_IR;
                EX2_IR:  state <= i_tms ? UPD_IR : SH_IR;
                UPD_IR:  state <= i_tms ? SEL_DR : RTI;
                default: state <= TLR;
            endcase
        end
    end

    // NOTE: every variable assigned in this always_comb gets a default first,
    // otherwise unmatched instructions would infer latches.
    always_comb begin
        user_hit = '0;
        user_rb  = '0;
        for (int k = 0; k < NUM_USER; k++) begin
            if (ir == IR_W'(4 + k)) begin
                user_hit[k] = 1'b1;
                user_rb     = user_data[k*DR_W +: DR_W];
            end
        end
        if (ir == IR_W'(1))
            dr_sel = SEL_IDCODE;
        else if (ir == IR_W'(2))
            dr_sel = SEL_SAMPLE;
        else if (|user_hit)
            dr_sel = SEL_USER;
        else
            dr_sel = SEL_BYPASS;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of the others.
    always_ff @(posedge i_tclk or posedge i_trst) begin
        if (i_trst) begin
            ir          <= IR_W'(1);
            ir_sr       <= '0;
            bypass_sr   <= 1'b0;
            id_sr       <= '0;
            data_sr     <= '0;
            user_data   <= '0;
            user_update <= '0;
        end else begin
            user_update <= '0;
            case (state)
                TLR:    ir    <= IR_W'(1);
                CAP_IR: ir_sr <= IR_W'(1);
                SH_IR:  ir_sr <= {i_tdi, ir_sr[IR_W-1:1]};
                UPD_IR: ir    <= ir_sr;
                CAP_DR: begin
                    case (dr_sel)
                        SEL_IDCODE: id_sr     <= IDCODE;
                        SEL_SAMPLE: data_sr   <= i_bsr;
                        SEL_USER:   data_sr   <= user_rb;
                        default:    bypass_sr <= 1'b0;
                    endcase
                end
                SH_DR: begin
                    case (dr_sel)
                        SEL_IDCODE: id_sr     <= {i_tdi, id_sr[31:1]};
                        SEL_SAMPLE,
                        SEL_USER:   data_sr   <= {i_tdi, data_sr[DR_W-1:1]};
                        default:    bypass_sr <= i_tdi;
                    endcase
                end
                UPD_DR: begin
                    // Strobe fires on every write, even if the value is unchanged.
                    for (int k = 0; k < NUM_USER; k++) begin
                        if (user_hit[k]) begin
                            user_data[k*DR_W +: DR_W] <= data_sr;
                            user_update[k]            <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_tdo = 1'b0;
        if (state == SH_IR) begin
            o_tdo = ir_sr[0];
        end else if (state == SH_DR) begin
            case (dr_sel)
                SEL_IDCODE: o_tdo = id_sr[0];
                SEL_SAMPLE,
                SEL_USER:   o_tdo = data_sr[0];
                default:    o_tdo = bypass_sr;
            endcase
        end
    end

    assign o_tdoEn      = (state == SH_DR) || (state == SH_IR);
    assign o_userData   = user_data;
    assign o_userUpdate = user_update;
    assign o_instr      = ir;
    assign o_state      = state;

endmodule

// File: tb/tb_jtag_tap_multi.sv
// Directed self-checking bench for jtag_tap_multi: IDCODE, BYPASS, USER,
// SAMPLE scans, IR capture pattern, TMS reset and TRST abort.
module tb_jtag_tap_multi;

    localparam int IR_W     = 4;
    localparam int DR_W     = 8;
    localparam int NUM_USER = 2;

    logic                     tclk;
    logic                     trst;
    logic                     tdi;
    logic                     tms;
    logic                     tdo;
    logic                     tdo_en;
    logic [DR_W-1:0]          bsr;
    logic [NUM_USER*DR_W-1:0] user_data;
    logic [NUM_USER-1:0]      user_update;
    logic [IR_W-1:0]          instr;
    logic [3:0]               state;

    int checks = 0;
    int errors = 0;

    jtag_tap_multi #(
        .IR_W(IR_W), .DR_W(DR_W), .NUM_USER(NUM_USER), .IDCODE(32'h1234_5001)
    ) dut (
        .i_tclk(tclk), .i_trst(trst), .i_tdi(tdi), .i_tms(tms),
        .o_tdo(tdo), .o_tdoEn(tdo_en), .i_bsr(bsr),
        .o_userData(user_data), .o_userUpdate(user_update),
        .o_instr(instr), .o_state(state)
    );

    initial begin
        tclk = 1'b0;
        forever #5 tclk = ~tclk;
    end

    // Inputs change 1 ns after the rising edge; outputs are read there too.
    task automatic step(input logic m, input logic d);
        tms = m;
        tdi = d;
        @(posedge tclk);
        #1;
    endtask

    // From RTI: load an instruction, returning what TDO showed during ShIR.
    task automatic load_ir(input logic [IR_W-1:0] value, output logic [IR_W-1:0] cap);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < IR_W; i++) begin
            cap[i] = tdo;
            step(i == IR_W - 1, value[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
    endtask

    // From RTI: full DR scan of n bits ending in RTI right after UpdDR.
    task automatic scan_dr(input int n, input logic [31:0] din, output logic [31:0] dout,
                           output logic [31:0] en, output logic [NUM_USER-1:0] upd);
        dout = '0;
        en   = '0;
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < n; i++) begin
            dout[i] = tdo;
            en[i]   = tdo_en;
            step(i == n - 1, din[i]);
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        upd = user_update;
    endtask

    task automatic test_reset();
        trst = 1'b1;
        tms  = 1'b1;
        tdi  = 1'b0;
        bsr  = '0;
        #3;
        checks++; if (state !== 4'hF) begin errors++; $display("FAIL reset_state got %h exp f", state); end
        checks++; if (instr !== 4'h1) begin errors++; $display("FAIL reset_instr got %h exp 1", instr); end
        checks++; if (tdo !== 1'b0 || tdo_en !== 1'b0) begin errors++; $display("FAIL reset_tdo got %b/%b exp 0/0", tdo, tdo_en); end
        checks++; if (user_data !== 16'h0000 || user_update !== 2'b00) begin errors++; $display("FAIL reset_user got %h/%b exp 0000/00", user_data, user_update); end
        #9 trst = 1'b0;
        step(1'b0, 1'b0);
        checks++; if (state !== 4'hC) begin errors++; $display("FAIL reset_to_rti got %h exp c", state); end
    endtask

    task automatic test_idcode();
        logic [31:0] d, en;
        logic [NUM_USER-1:0] upd;
        scan_dr(32, 32'h0, d, en, upd);
        checks++; if (d !== 32'h1234_5001) begin errors++; $display("FAIL idcode_data got %h exp 12345001", d); end
        checks++; if (en !== 32'hFFFF_FFFF) begin errors++; $display("FAIL idcode_tdoen got %h exp ffffffff", en); end
        checks++; if (tdo_en !== 1'b0) begin errors++; $display("FAIL idcode_tdoen_after got %b exp 0", tdo_en); end
    endtask

    task automatic test_bypass();
        logic [IR_W-1:0] cap;
        logic [31:0] d, en;
        logic [NUM_USER-1:0] upd;
        load_ir(4'hF, cap);
        checks++; if (instr !== 4'hF) begin errors++; $display("FAIL bypass_instr got %h exp f", instr); end
        scan_dr(4, 32'b1101, d, en, upd);
        checks++; if (d[3:0] !== 4'b1010) begin errors++; $display("FAIL bypass_data got %b exp 1010", d[3:0]); end
    endtask

    task automatic test_user_write();
        logic [IR_W-1:0] cap;
        logic [31:0] d, en;
        logic [NUM_USER-1:0] upd;
        load_ir(4'h4, cap);
        scan_dr(8, 32'hA5, d, en, upd);
        checks++; if (d[7:0] !== 8'h00) begin errors++; $display("FAIL user0_first_capture got %h exp 00", d[7:0]); end
        checks++; if (user_data !== 16'h00A5) begin errors++; $display("FAIL user0_data got %h exp 00a5", user_data); end
        checks++; if (upd !== 2'b01) begin errors++; $display("FAIL user0_strobe got %b exp 01", upd); end
        step(1'b0, 1'b0);
        checks++; if (user_update !== 2'b00) begin errors++; $display("FAIL user0_strobe_width got %b exp 00", user_update); end
        scan_dr(8, 32'hA5, d, en, upd);
        checks++; if (d[7:0] !== 8'hA5) begin errors++; $display("FAIL user0_readback got %h exp a5", d[7:0]); end
        checks++; if (upd !== 2'b01) begin errors++; $display("FAIL user0_strobe_same_data got %b exp 01", upd); end
    endtask

    task automatic test_sample();
        logic [IR_W-1:0] cap;
        logic [31:0] d, en;
        logic [NUM_USER-1:0] upd;
        bsr = 8'h3C;
        load_ir(4'h2, cap);
        scan_dr(8, 32'hFF, d, en, upd);
        checks++; if (d[7:0] !== 8'h3C) begin errors++; $display("FAIL sample_data got %h exp 3c", d[7:0]); end
        checks++; if (user_data !== 16'h00A5 || upd !== 2'b00) begin errors++; $display("FAIL sample_user_untouched got %h/%b exp 00a5/00", user_data, upd); end
    endtask

    task automatic test_ir_capture_and_tlr();
        logic [IR_W-1:0] cap;
        load_ir(4'h5, cap);
        checks++; if (cap !== 4'b0001) begin errors++; $display("FAIL ir_capture got %b exp 0001", cap); end
        checks++; if (instr !== 4'h5) begin errors++; $display("FAIL ir_user1 got %h exp 5", instr); end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        checks++; if (state !== 4'h2) begin errors++; $display("FAIL shdr_state got %h exp 2", state); end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        checks++; if (state !== 4'hF) begin errors++; $display("FAIL tms_reset_state got %h exp f", state); end
        step(1'b1, 1'b0);
        checks++; if (instr !== 4'h1) begin errors++; $display("FAIL tms_reset_instr got %h exp 1", instr); end
        checks++; if (user_data !== 16'h00A5) begin errors++; $display("FAIL tms_reset_user_kept got %h exp 00a5", user_data); end
    endtask

    task automatic test_trst_abort();
        logic [IR_W-1:0] cap;
        int pulses;
        step(1'b0, 1'b0);
        load_ir(4'h5, cap);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
        checks++; if (tdo_en !== 1'b1) begin errors++; $display("FAIL trst_pre_shift got %b exp 1", tdo_en); end
        #2 trst = 1'b1;
        #1;
        checks++; if (state !== 4'hF || instr !== 4'h1) begin errors++; $display("FAIL trst_state got %h/%h exp f/1", state, instr); end
        checks++; if (tdo !== 1'b0 || tdo_en !== 1'b0) begin errors++; $display("FAIL trst_tdo got %b/%b exp 0/0", tdo, tdo_en); end
        checks++; if (user_data !== 16'h0000) begin errors++; $display("FAIL trst_user_clear got %h exp 0000", user_data); end
        pulses = 0;
        @(posedge tclk);
        #1;
        if (user_update !== 2'b00) pulses++;
        #3 trst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            if (user_update !== 2'b00) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL trst_no_strobe got %0d pulses exp 0", pulses); end
        checks++; if (state !== 4'hF) begin errors++; $display("FAIL trst_hold_tlr got %h exp f", state); end
    endtask

    initial begin
        test_reset();
        test_idcode();
        test_bypass();
        test_user_write();
        test_sample();
        test_ir_capture_and_tlr();
        test_trst_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
